// File: rtl/compound_responder_pkg.sv
// Shared types for the compound responder: request/response payloads, storage
// array type, FSM states and status-word bit positions.
package scam_model_types;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned RING_DEPTH = 5;
  localparam int unsigned PTR_W      = 3;

  localparam int unsigned STAT_CNT_W    = 3;
  localparam int unsigned STAT_ERR_BIT  = 8;
  localparam int unsigned STAT_OVW_BIT  = 9;
  localparam int unsigned STAT_MODE_BIT = 10;

  typedef enum logic {
    MODE_READ  = 1'b0,
    MODE_WRITE = 1'b1
  } Mode;

  typedef struct packed {
    Mode               mode;
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] y;
  } CompoundType;

  typedef struct packed {
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] y;
  } record_t;

  typedef logic [RING_DEPTH-1:0][DATA_W-1:0] int_5;

  typedef enum logic {
    S_REQ  = 1'b0,
    S_RESP = 1'b1
  } responder_state_t;

endpackage

// File: rtl/compound_responder_ring_buffer.sv
// Five-entry ring buffer with wrapping pointers; overwrite replaces the oldest
// entry when full by advancing both pointers together.
module compound_ring_buffer
  import scam_model_types::*;
#(
  parameter int unsigned DEPTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  overwrite,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata,
  output logic [STAT_CNT_W-1:0] count,
  output logic                  full,
  output logic                  empty
);

  int_5                  mem_q, mem_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [STAT_CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push || overwrite) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = ptr_next(wr_ptr_q);
    end
    if (pop || overwrite) begin
      rd_ptr_d = ptr_next(rd_ptr_q);
    end
    if (push && !pop) begin
      count_d = count_q + STAT_CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - STAT_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == STAT_CNT_W'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/compound_responder.sv
// Request/response responder: accepts one read/write request, presents one
// registered response, and returns to accepting requests after it is taken.
module compound_responder
  import scam_model_types::*;
#(
  parameter int unsigned DEPTH = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  CompoundType req_sig,
  input  logic        req_sync,
  output logic        req_notify,
  output record_t     resp_sig,
  input  logic        resp_sync,
  output logic        resp_notify
);

  responder_state_t      state_q, state_d;
  record_t               resp_q, resp_d;
  logic                  req_notify_q, req_notify_d;
  logic                  resp_notify_q, resp_notify_d;

  logic                  push, pop, overwrite, full, empty, y_flag;
  logic [DATA_W-1:0]     rdata;
  logic [STAT_CNT_W-1:0] count, count_after;

  compound_ring_buffer #(.DEPTH(DEPTH)) u_ring (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .overwrite(overwrite),
    .wdata    (req_sig.x),
    .rdata    (rdata),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  // Buffer is updated on the same edge the request is accepted; the response
  // reports the state after that update.
  always_comb begin
    state_d     = state_q;
    resp_d      = resp_q;
    push        = 1'b0;
    pop         = 1'b0;
    overwrite   = 1'b0;
    count_after = count;
    y_flag      = (req_sig.y != '0);
    case (state_q)
      S_REQ: begin
        if (req_sync) begin
          state_d = S_RESP;
          resp_d  = '0;
          if (req_sig.mode == MODE_WRITE) begin
            resp_d.x                = req_sig.x;
            resp_d.y[STAT_MODE_BIT] = 1'b1;
            if (!full) begin
              push        = 1'b1;
              count_after = count + STAT_CNT_W'(1);
            end else if (y_flag) begin
              overwrite              = 1'b1;
              resp_d.y[STAT_OVW_BIT] = 1'b1;
            end else begin
              resp_d.y[STAT_ERR_BIT] = 1'b1;
            end
          end else begin
            if (!empty) begin
              resp_d.x = rdata;
              if (!y_flag) begin
                pop         = 1'b1;
                count_after = count - STAT_CNT_W'(1);
              end
            end else begin
              resp_d.y[STAT_ERR_BIT] = 1'b1;
            end
          end
          resp_d.y[STAT_CNT_W-1:0] = count_after;
        end
      end
      S_RESP: begin
        if (resp_sync) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
    req_notify_d  = (state_d == S_REQ);
    resp_notify_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_REQ;
      resp_q        <= '0;
      req_notify_q  <= 1'b1;
      resp_notify_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      resp_q        <= resp_d;
      req_notify_q  <= req_notify_d;
      resp_notify_q <= resp_notify_d;
    end
  end

  assign req_notify  = req_notify_q;
  assign resp_notify = resp_notify_q;
  assign resp_sig    = resp_q;

endmodule
